// File: rtl/sqrt_pkg.sv
// Shared types and constants for the iterative square-root unit.
// SQRT_ROUND_NEAREST_EN adds a guard iteration and round-to-nearest-even.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Exponent encoding used for signed zero.
  function automatic int zero_exp(input int exp_w);
    return -(1 << (exp_w - 3)) + 1;
  endfunction

  // Exponent encoding used for NaN and infinity results.
  function automatic int spec_exp(input int exp_w);
    return 1 << (exp_w - 3);
  endfunction

  // The rounding build needs one extra root bit to act as the guard bit.
  function automatic int niter(input int mant_w);
`ifdef SQRT_ROUND_NEAREST_EN
    return mant_w + 1;
`else
    return mant_w;
`endif
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-recurrence step: consumes two radicand bits, yields one root bit.
module sqrt_step #(
  parameter int MANT_W = 11
) (
  input  logic [MANT_W+2:0] rem,
  input  logic [MANT_W:0]   root,
  input  logic [1:0]        pair,
  output logic [MANT_W+2:0] rem_next,
  output logic [MANT_W:0]   root_next
);

  logic [MANT_W+4:0] shifted;
  logic [MANT_W+4:0] trial;
  logic              fits;

  // Compare at full width so no remainder bit is silently dropped.
  always_comb begin
    shifted   = {rem, pair};
    trial     = {2'b00, root, 2'b01};
    fits      = (shifted >= trial);
    rem_next  = fits ? (shifted[MANT_W+2:0] - trial[MANT_W+2:0]) : shifted[MANT_W+2:0];
    root_next = {root[MANT_W-1:0], fits};
  end

endmodule

// File: rtl/sqrt_iter_param.sv
// Iterative floating-point square root with a valid/ready handshake on both sides.
// Define SQRT_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the root is truncated.
module sqrt_iter_param
  import sqrt_pkg::*;
#(
  parameter int MANT_W = 11,
  parameter int EXP_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W-1:0] mant_in,
  input  logic              is_nan_in,
  input  logic              is_pinf_in,
  input  logic              is_ninf_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mant_out,
  output logic              nan_out,
  output logic              pinf_out,
  output logic              zero_out
);

  localparam int NITER  = niter(MANT_W);
  localparam int CNT_W  = $clog2(NITER + 1);
  localparam int RAD_W  = 2 * MANT_W + 2;
  localparam int REM_W  = MANT_W + 3;
  localparam int ROOT_W = MANT_W + 1;

  localparam logic [EXP_W-1:0]  ZERO_E   = EXP_W'(zero_exp(EXP_W));
  localparam logic [EXP_W-1:0]  SPEC_E   = EXP_W'(spec_exp(EXP_W));
  localparam logic [MANT_W-1:0] MANT_MSB = {1'b1, {(MANT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  NITER_C  = CNT_W'(NITER);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t              state;
  logic [RAD_W-1:0]    rad;
  logic [REM_W-1:0]    rem;
  logic [ROOT_W-1:0]   root;
  logic [CNT_W-1:0]    cnt;
  logic [EXP_W-1:0]    exp_res;

  logic [REM_W-1:0]    rem_next;
  logic [ROOT_W-1:0]   root_next;
  logic                is_zero;
  logic [EXP_W-1:0]    exp_half;
  logic [RAD_W-1:0]    rad_load;
  logic [MANT_W-1:0]   fin_mant;
  logic [EXP_W-1:0]    fin_exp;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  sqrt_step #(
    .MANT_W(MANT_W)
  ) u_step (
    .rem      (rem),
    .root     (root),
    .pair     (rad[RAD_W-1 -: 2]),
    .rem_next (rem_next),
    .root_next(root_next)
  );

  // An odd exponent is absorbed by doubling the radicand; the floor shift then halves it exactly.
  always_comb begin
    is_zero  = (exp_in == ZERO_E) && (mant_in == '0);
    exp_half = $signed(exp_in) >>> 1;
    rad_load = exp_in[0] ? {mant_in, {(MANT_W+2){1'b0}}}
                         : {1'b0, mant_in, {(MANT_W+1){1'b0}}};
  end

`ifdef SQRT_ROUND_NEAREST_EN
  logic [MANT_W-1:0] quot;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [MANT_W:0]   rounded;

  // Ties go to even; a carry out to 2.0 renormalises into the next binade.
  always_comb begin
    quot     = root_next[MANT_W:1];
    guard    = root_next[0];
    sticky   = |rem_next;
    round_up = guard & (sticky | quot[0]);
    rounded  = {1'b0, quot} + (MANT_W+1)'(round_up);
    if (rounded[MANT_W]) begin
      fin_mant = MANT_MSB;
      fin_exp  = exp_res + EXP_W'(1);
    end else begin
      fin_mant = rounded[MANT_W-1:0];
      fin_exp  = exp_res;
    end
  end
`else
  always_comb begin
    fin_mant = root_next[MANT_W-1:0];
    fin_exp  = exp_res;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rad      <= '0;
      rem      <= '0;
      root     <= '0;
      cnt      <= '0;
      exp_res  <= '0;
      sign_out <= 1'b0;
      exp_out  <= '0;
      mant_out <= '0;
      nan_out  <= 1'b0;
      pinf_out <= 1'b0;
      zero_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            nan_out  <= 1'b0;
            pinf_out <= 1'b0;
            zero_out <= 1'b0;
            // Zero is tested before sign so that -0 keeps its sign instead of becoming NaN.
            if (is_nan_in || is_ninf_in) begin
              nan_out  <= 1'b1;
              sign_out <= 1'b1;
              exp_out  <= SPEC_E;
              mant_out <= MANT_MSB;
              state    <= DONE;
            end else if (is_pinf_in) begin
              pinf_out <= 1'b1;
              sign_out <= 1'b0;
              exp_out  <= SPEC_E;
              mant_out <= '0;
              state    <= DONE;
            end else if (is_zero) begin
              zero_out <= 1'b1;
              sign_out <= sign_in;
              exp_out  <= ZERO_E;
              mant_out <= '0;
              state    <= DONE;
            end else if (sign_in) begin
              nan_out  <= 1'b1;
              sign_out <= 1'b1;
              exp_out  <= SPEC_E;
              mant_out <= MANT_MSB;
              state    <= DONE;
            end else begin
              sign_out <= 1'b0;
              rad      <= rad_load;
              rem      <= '0;
              root     <= '0;
              cnt      <= NITER_C;
              exp_res  <= exp_half;
              state    <= ITER;
            end
          end
        end
        ITER: begin
          rad  <= {rad[RAD_W-3:0], 2'b00};
          rem  <= rem_next;
          root <= root_next;
          cnt  <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            mant_out <= fin_mant;
            exp_out  <= fin_exp;
            sign_out <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_iter_param.sv
// Directed, table-driven bench for sqrt_iter_param (MANT_W=11, EXP_W=7).
// Expected mantissas follow SQRT_ROUND_NEAREST_EN when it is defined.
module tb_sqrt_iter_param;

`ifdef SQRT_ROUND_NEAREST_EN
  localparam int NITER = 12;
  localparam logic [10:0] ROOT3   = 11'h6EE;
  localparam logic [10:0] ROOT125 = 11'h479;
`else
  localparam int NITER = 11;
  localparam logic [10:0] ROOT3   = 11'h6ED;
  localparam logic [10:0] ROOT125 = 11'h478;
`endif
  localparam int N1 = NITER + 1;
  localparam int NVEC = 15;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [6:0]  exp_in;
  logic [10:0] mant_in;
  logic        is_nan_in;
  logic        is_pinf_in;
  logic        is_ninf_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [6:0]  exp_out;
  logic [10:0] mant_out;
  logic        nan_out;
  logic        pinf_out;
  logic        zero_out;

  int total_checks = 0;
  int passed_checks = 0;

  typedef struct {
    logic        sign;
    logic [6:0]  exp;
    logic [10:0] mant;
    logic [2:0]  cls;    // {nan, pinf, ninf}
    logic        esign;
    logic [6:0]  eexp;
    logic [10:0] emant;
    logic [2:0]  eflags; // {nan_out, pinf_out, zero_out}
    int          elat;
  } vec_t;

  vec_t vecs[NVEC];

  sqrt_iter_param #(
    .MANT_W(11),
    .EXP_W (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .is_nan_in (is_nan_in),
    .is_pinf_in(is_pinf_in),
    .is_ninf_in(is_ninf_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_out  (sign_out),
    .exp_out   (exp_out),
    .mant_out  (mant_out),
    .nan_out   (nan_out),
    .pinf_out  (pinf_out),
    .zero_out  (zero_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic [6:0] e, input logic [10:0] m,
                              input logic [2:0] c, input logic es, input logic [6:0] ee,
                              input logic [10:0] em, input logic [2:0] ef, input int lat);
    vec_t v;
    v.sign = s; v.exp = e; v.mant = m; v.cls = c;
    v.esign = es; v.eexp = ee; v.emant = em; v.eflags = ef; v.elat = lat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual === expected) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Offers one operand in IDLE and waits (bounded) for out_valid; latency counts edges from the accept edge.
  task automatic applyStimulus(input vec_t v, output int lat);
    sign_in    = v.sign;
    exp_in     = v.exp;
    mant_in    = v.mant;
    is_nan_in  = v.cls[2];
    is_pinf_in = v.cls[1];
    is_ninf_in = v.cls[0];
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic checkResult(input string tag, input vec_t v, input int lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'(v.elat));
    checkOutput({tag, " sign"}, 32'(sign_out), 32'(v.esign));
    checkOutput({tag, " exp"}, 32'(exp_out), 32'(v.eexp));
    checkOutput({tag, " mant"}, 32'(mant_out), 32'(v.emant));
    checkOutput({tag, " flags"}, 32'({nan_out, pinf_out, zero_out}), 32'(v.eflags));
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, " idle after ready"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0]  = mk(1'b0, 7'd2,     11'h400, 3'b000, 1'b0, 7'd1,     11'h400, 3'b000, N1);
    vecs[1]  = mk(1'b0, 7'd1,     11'h600, 3'b000, 1'b0, 7'd0,     ROOT3,   3'b000, N1);
    vecs[2]  = mk(1'b1, 7'd0,     11'h400, 3'b000, 1'b1, 7'd16,    11'h400, 3'b100, 1);
    vecs[3]  = mk(1'b1, 7'h71,    11'h000, 3'b000, 1'b1, 7'h71,    11'h000, 3'b001, 1);
    vecs[4]  = mk(1'b0, 7'h71,    11'h000, 3'b000, 1'b0, 7'h71,    11'h000, 3'b001, 1);
    vecs[5]  = mk(1'b0, 7'd3,     11'h500, 3'b100, 1'b1, 7'd16,    11'h400, 3'b100, 1);
    vecs[6]  = mk(1'b0, 7'd16,    11'h000, 3'b010, 1'b0, 7'd16,    11'h000, 3'b010, 1);
    vecs[7]  = mk(1'b1, 7'd16,    11'h000, 3'b001, 1'b1, 7'd16,    11'h400, 3'b100, 1);
    vecs[8]  = mk(1'b0, 7'd0,     11'h400, 3'b000, 1'b0, 7'd0,     11'h400, 3'b000, N1);
    vecs[9]  = mk(1'b0, 7'd1,     11'h400, 3'b000, 1'b0, 7'd0,     11'h5A8, 3'b000, N1);
    vecs[10] = mk(1'b0, 7'h7E,    11'h400, 3'b000, 1'b0, 7'h7F,    11'h400, 3'b000, N1);
    vecs[11] = mk(1'b0, 7'h7D,    11'h400, 3'b000, 1'b0, 7'h7E,    11'h5A8, 3'b000, N1);
    vecs[12] = mk(1'b0, 7'd14,    11'h500, 3'b000, 1'b0, 7'd7,     ROOT125, 3'b000, N1);
    vecs[13] = mk(1'b0, 7'h71,    11'h400, 3'b000, 1'b0, 7'h78,    11'h5A8, 3'b000, N1);
    vecs[14] = mk(1'b0, 7'd1,     11'h7FF, 3'b000, 1'b0, 7'd0,     11'h7FF, 3'b000, N1);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sign_in = 1'b0; exp_in = '0; mant_in = '0;
    is_nan_in = 1'b0; is_pinf_in = 1'b0; is_ninf_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset handshake", 32'({in_ready, out_valid}), 32'b10);
    checkOutput("reset fields", 32'({sign_out, exp_out, mant_out}), 32'd0);
    checkOutput("reset flags", 32'({nan_out, pinf_out, zero_out}), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], lat);
      checkResult($sformatf("vec%0d", i), vecs[i], lat);
      releaseResult($sformatf("vec%0d", i));
    end

    // Back-pressure: result must stay frozen while out_ready is low.
    applyStimulus(vecs[1], lat);
    checkResult("hold", vecs[1], lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold cycle%0d", c),
                  32'({out_valid, in_ready, sign_out, exp_out, mant_out, nan_out, pinf_out, zero_out}),
                  32'({1'b1, 1'b0, 1'b0, 7'd0, ROOT3, 3'b000}));
    end
    releaseResult("hold");

    // Reset during the fifth iteration discards the operation.
    sign_in = 1'b0; exp_in = 7'd2; mant_in = 11'h400; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("mid-iter reset state", 32'({in_ready, out_valid}), 32'b10);
    seen = 0;
    for (int c = 0; c < NITER + 3; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checkOutput("mid-iter reset no pulse", 32'(seen), 32'd0);
    applyStimulus(vecs[0], lat);
    checkResult("after reset", vecs[0], lat);
    releaseResult("after reset");

    // Reset wins over a simultaneous accept.
    sign_in = 1'b0; exp_in = 7'd2; mant_in = 11'h400; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; rst = 1'b0;
    checkOutput("reset priority ready", 32'({in_ready, out_valid}), 32'b10);
    seen = 0;
    for (int c = 0; c < NITER + 3; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checkOutput("reset priority no pulse", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
